// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// Holds the FSM state encoding, the round-robin search and the timeout counter width.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A TIMEOUT of 1 would otherwise give a zero-width counter.
    function automatic int tcnt_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    // First requesting index, starting at ptr and wrapping modulo 4.
    function automatic logic [1:0] next_grant(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        next_grant = ptr;
        found      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                next_grant = idx;
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain N-bit 4:1 datapath mux, steered by the arbiter's registered select.
module mux4 #(
    parameter int N = 64
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   s,
    output logic [N-1:0] y
);

    // Select one of the four requester words.
    always_comb begin
        y = {N{1'b0}};
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = {N{1'b0}};
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux; a granted requester holds the mux until
// its last beat or until it has been idle for TIMEOUT cycles.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   last,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready
);

    localparam int TW = tcnt_w(TIMEOUT);

    arb_state_t      state_r, state_nxt_s;
    logic [3:0]      gnt_r, gnt_nxt_s;
    logic [1:0]      sel_r, sel_nxt_s;
    logic [1:0]      ptr_r, ptr_nxt_s;
    logic [TW-1:0]   tcnt_r, tcnt_nxt_s;
    logic            out_valid_r, out_valid_nxt_s;
    logic [N-1:0]    out_data_r, out_data_nxt_s;
    logic [N-1:0]    mux_y_s;
    logic [1:0]      grant_idx_s;
    logic            fire_s;
    logic            release_s;

    assign grant_idx_s = next_grant(req, ptr_r);

    mux4 #(.N(N)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s  (sel_r),
        .y  (mux_y_s)
    );

    // Next-state, grant, timeout and output-stage logic.
    always_comb begin
        state_nxt_s     = state_r;
        gnt_nxt_s       = gnt_r;
        sel_nxt_s       = sel_r;
        ptr_nxt_s       = ptr_r;
        tcnt_nxt_s      = tcnt_r;
        fire_s          = 1'b0;
        release_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    gnt_nxt_s   = onehot4(grant_idx_s);
                    sel_nxt_s   = grant_idx_s;
                    tcnt_nxt_s  = {TW{1'b0}};
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                fire_s = req[sel_r] & (~out_valid_r | out_ready);
                if (fire_s) begin
                    tcnt_nxt_s = {TW{1'b0}};
                    release_s  = last[sel_r];
                end else if (!req[sel_r]) begin
                    if (tcnt_r == TW'(TIMEOUT - 1)) begin
                        tcnt_nxt_s = {TW{1'b0}};
                        release_s  = 1'b1;
                    end else begin
                        tcnt_nxt_s = tcnt_r + TW'(1);
                    end
                end else begin
                    // Stalled by the output stage: the idle timer does not run.
                    tcnt_nxt_s = tcnt_r;
                end
                if (release_s) begin
                    gnt_nxt_s   = 4'b0000;
                    ptr_nxt_s   = sel_r + 2'd1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                gnt_nxt_s   = 4'b0000;
                state_nxt_s = IDLE;
            end
        endcase

        // A drain in the same cycle as a fire simply reloads the stage.
        if (fire_s) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = mux_y_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_nxt_s = 1'b0;
            out_data_nxt_s  = out_data_r;
        end else begin
            out_valid_nxt_s = out_valid_r;
            out_data_nxt_s  = out_data_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            gnt_r       <= 4'b0000;
            sel_r       <= 2'd0;
            ptr_r       <= 2'd0;
            tcnt_r      <= {TW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {N{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            sel_r       <= sel_nxt_s;
            ptr_r       <= ptr_nxt_s;
            tcnt_r      <= tcnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected beats go into a scoreboard queue as they
// are driven and are popped when the consumer accepts a beat.
module tb_mux4_rr_arbiter;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [3:0]   last = 4'b0000;
    logic [N-1:0] d0 = 64'd0;
    logic [N-1:0] d1 = 64'd0;
    logic [N-1:0] d2 = 64'd0;
    logic [N-1:0] d3 = 64'd0;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] sb_q[$];
    logic [N-1:0] dv [4];

    mux4_rr_arbiter #(.N(N), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Every accepted beat must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_beat", out_data, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check_eq("beat", out_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        // Test 1: reset state and single-beat latency
        do_reset();
        check_eq("rst_gnt", {60'd0, gnt}, 64'd0);
        check_eq("rst_sel", {62'd0, sel}, 64'd0);
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_data", out_data, 64'd0);
        req = 4'b0001; last = 4'b0001; d0 = 64'hA; out_ready = 1'b1;
        tick();
        check_eq("t1_gnt_c1", {60'd0, gnt}, 64'b0001);
        check_eq("t1_valid_c1", {63'd0, out_valid}, 64'd0);
        sb_q.push_back(64'hA);
        tick();
        check_eq("t1_valid_c2", {63'd0, out_valid}, 64'd1);
        check_eq("t1_data_c2", out_data, 64'hA);
        check_eq("t1_gnt_c2", {60'd0, gnt}, 64'd0);
        req = 4'b0000; last = 4'b0000;
        tick();
        // ptr must now be 1: requesters 0 and 1 both ask, 1 wins
        req = 4'b0011; last = 4'b0011; d1 = 64'hB;
        tick();
        check_eq("t1_ptr_gnt", {60'd0, gnt}, 64'b0010);
        check_eq("t1_ptr_sel", {62'd0, sel}, 64'd1);
        sb_q.push_back(64'hB);
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();

        // Test 2: all requesting, single-beat bursts, wrap
        do_reset();
        dv[0] = 64'h10; dv[1] = 64'h11; dv[2] = 64'h12; dv[3] = 64'h13;
        d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
        req = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t2_gnt", {60'd0, gnt}, 64'd1 << (k % 4));
            check_eq("t2_sel", {62'd0, sel}, 64'(k % 4));
            sb_q.push_back(dv[k % 4]);
            tick();
            check_eq("t2_released", {60'd0, gnt}, 64'd0);
        end

        // Test 3: 4-beat burst from requester 2, others ignored, then grant 3
        req = 4'b0100; last = 4'b0000;
        tick();
        check_eq("t3_gnt", {60'd0, gnt}, 64'b0100);
        req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            d2 = 64'h20 + 64'(b);
            last = (b == 3) ? 4'b0100 : 4'b0000;
            sb_q.push_back(64'h20 + 64'(b));
            tick();
            check_eq("t3_valid", {63'd0, out_valid}, 64'd1);
            check_eq("t3_data", out_data, 64'h20 + 64'(b));
            check_eq("t3_gnt_burst", {60'd0, gnt}, (b == 3) ? 64'd0 : 64'b0100);
        end
        req = 4'b1011; last = 4'b1111; d3 = 64'h33;
        tick();
        check_eq("t3_next_gnt", {60'd0, gnt}, 64'b1000);
        check_eq("t3_next_sel", {62'd0, sel}, 64'd3);
        sb_q.push_back(64'h33);
        tick();
        check_eq("t3_next_data", out_data, 64'h33);
        req = 4'b0000; last = 4'b0000;

        // Test 4: consumer stall mid-burst
        req = 4'b0001;
        tick();
        check_eq("t4_gnt", {60'd0, gnt}, 64'b0001);
        d0 = 64'h40; out_ready = 1'b1;
        sb_q.push_back(64'h40);
        tick();
        check_eq("t4_first", out_data, 64'h40);
        d0 = 64'h41; out_ready = 1'b0;
        sb_q.push_back(64'h41);
        for (int s = 0; s < 3; s++) begin
            tick();
            check_eq("t4_stall_data", out_data, 64'h40);
            check_eq("t4_stall_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("t4_resume", out_data, 64'h41);
        d0 = 64'h42; last = 4'b0001;
        sb_q.push_back(64'h42);
        tick();
        check_eq("t4_last", out_data, 64'h42);
        check_eq("t4_released", {60'd0, gnt}, 64'd0);
        req = 4'b0000; last = 4'b0000;
        tick();

        // Test 5: granted requester goes idle without last; forced release after 16 cycles
        req = 4'b0010;
        tick();
        check_eq("t5_gnt", {60'd0, gnt}, 64'b0010);
        req = 4'b0000;
        repeat (15) tick();
        check_eq("t5_hold15", {60'd0, gnt}, 64'b0010);
        tick();
        check_eq("t5_timeout", {60'd0, gnt}, 64'd0);
        check_eq("t5_no_beat", {63'd0, out_valid}, 64'd0);
        req = 4'b0101; last = 4'b0101; d0 = 64'h50; d2 = 64'h52;
        tick();
        check_eq("t5_ptr_gnt", {60'd0, gnt}, 64'b0100);
        sb_q.push_back(64'h52);
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();

        // Test 6: asynchronous reset with a buffered beat
        req = 4'b1000; last = 4'b0000; d3 = 64'h60; out_ready = 1'b1;
        tick();
        check_eq("t6_gnt", {60'd0, gnt}, 64'b1000);
        out_ready = 1'b0;
        tick();
        check_eq("t6_buffered", {63'd0, out_valid}, 64'd1);
        d3 = 64'h61;
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_async_gnt", {60'd0, gnt}, 64'd0);
        check_eq("t6_async_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t6_async_data", out_data, 64'd0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        req = 4'b1010; last = 4'b1010; d1 = 64'h71; d3 = 64'h73; out_ready = 1'b1;
        tick();
        check_eq("t6_post_gnt", {60'd0, gnt}, 64'b0010);
        sb_q.push_back(64'h71);
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();
        tick();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
